mul_result_issuer: RTL

- Transmit-side sequencer that feeds the partial-sum adder tree.
- Collects the per-round multiplier product words for one kernel tile from the multiplier array over a valid/ready stream.
- Replays them to the adder as one gap-free burst, driving MUL_results, MUL_DATA_valid, wsize, wround and stride.
- Waits for the adder's Psum_valid before reporting tile completion.

---
 rtl/mul_result_issuer_if.sv | 25 ++
 rtl/mul_result_issuer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mul_result_issuer_if.sv
// Stream bundle between the multiplier array, the result issuer and the adder tree.
// The issuer takes the slave view; whatever drives products and Psum_valid takes the master view.
interface mul_result_issuer_if #(
    parameter int DATA_W = 73728
);
    logic              mul_in_valid;
    logic [DATA_W-1:0] mul_in_data;
    logic              mul_in_ready;
    logic [DATA_W-1:0] MUL_results;
    logic              MUL_DATA_valid;
    logic [3:0]        wsize;
    logic [2:0]        wround;
    logic              stride;
    logic              Psum_valid;

    modport master (
        output mul_in_valid, mul_in_data, Psum_valid,
        input  mul_in_ready, MUL_results, MUL_DATA_valid, wsize, wround, stride
    );

    modport slave (
        input  mul_in_valid, mul_in_data, Psum_valid,
        output mul_in_ready, MUL_results, MUL_DATA_valid, wsize, wround, stride
    );
endinterface

// File: rtl/mul_result_issuer.sv
// Buffers one tile's product words from the multiplier array and replays them
// to the adder tree as a gap-free burst, then waits for the partial sum.
module mul_result_issuer #(
    parameter int DATA_W     = 73728,
    parameter int MAX_ROUNDS = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic [3:0]              cfg_wsize,
    input  logic                    cfg_stride,
    mul_result_issuer_if.slave      io,
    output logic                    done,
    output logic                    err
);
    localparam int CW = $clog2(MAX_ROUNDS + 1);
    localparam int IW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BURST = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Round count per kernel size and stride; zero marks an illegal size code.
    function automatic logic [CW-1:0] rounds_f(input logic [3:0] ws, input logic st);
        logic [CW-1:0] n;
        case (ws)
            4'd0:    n = CW'(3'd1);
            4'd1:    n = st ? CW'(3'd1) : CW'(3'd2);
            4'd2:    n = st ? CW'(3'd2) : CW'(3'd4);
            default: n = '0;
        endcase
        return n;
    endfunction

    state_t            state_q;
    logic [CW-1:0]     rounds_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     bidx_q;
    logic [TW-1:0]     timer_q;
    logic              psum_seen_q;
    logic              ready_q;
    logic              valid_q;
    logic [DATA_W-1:0] results_q;
    logic [3:0]        wsize_q;
    logic [2:0]        wround_q;
    logic              stride_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] buf_q [MAX_ROUNDS];

    logic [CW-1:0]     start_rounds;
    logic              beat_accept;

    assign start_rounds = rounds_f(cfg_wsize, cfg_stride);
    assign beat_accept  = io.mul_in_valid & ready_q & (state_q == ST_LOAD);

    // Product buffer; contents are meaningless once count is cleared, so no reset.
    always_ff @(posedge clk) begin
        if (beat_accept) begin
            buf_q[count_q[IW-1:0]] <= io.mul_in_data;
        end
    end

    // Tile sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rounds_q    <= '0;
            count_q     <= '0;
            bidx_q      <= '0;
            timer_q     <= '0;
            psum_seen_q <= 1'b0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            results_q   <= '0;
            wsize_q     <= 4'd0;
            wround_q    <= 3'd0;
            stride_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        wsize_q     <= cfg_wsize;
                        stride_q    <= cfg_stride;
                        rounds_q    <= start_rounds;
                        count_q     <= '0;
                        psum_seen_q <= 1'b0;
                        if (start_rounds == '0) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (beat_accept) begin
                        count_q <= count_q + CW'(1'b1);
                        if ((count_q + CW'(1'b1)) == rounds_q) begin
                            ready_q <= 1'b0;
                            bidx_q  <= '0;
                            state_q <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    // An early partial sum is remembered so WAIT can finish at once.
                    psum_seen_q <= psum_seen_q | io.Psum_valid;
                    if (bidx_q < rounds_q) begin
                        valid_q   <= 1'b1;
                        results_q <= buf_q[bidx_q[IW-1:0]];
                        wround_q  <= 3'(bidx_q);
                        bidx_q    <= bidx_q + CW'(1'b1);
                    end else begin
                        valid_q  <= 1'b0;
                        wround_q <= 3'd0;
                        timer_q  <= '0;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (io.Psum_valid || psum_seen_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1'b1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign io.mul_in_ready   = ready_q;
    assign io.MUL_results    = results_q;
    assign io.MUL_DATA_valid = valid_q;
    assign io.wsize          = wsize_q;
    assign io.wround         = wround_q;
    assign io.stride         = stride_q;
    assign done              = done_q;
    assign err               = err_q;
endmodule
